req_sync_arbiter: RTL
=====================

# req_sync_arbiter

Round-robin arbiter that lets up to N asynchronous requesters share one single-owner resource. Each request line is synchronized into the `i_clk` domain, rising-edge detected and latched as a pending event. Pending events are granted one at a time, and each grant is held until the resource reports completion. The block sits between the asynchronous event sources (buttons, off-domain strobes) and the resource datapath.

## Interface
Parameters:
- `N`, 4: number of requesters, N >= 2.
- `SYNC_STAGES`, 2: flops per synchronizer chain, >= 2.
- `IDX_W`, `$clog2(N)`: grant index width (derived, not overridden).

Ports:
- `i_clk` in 1: single clock; all flops are on its rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_req` in N: asynchronous request levels; a rising edge is one event.
- `i_done` in 1: the resource has finished the current grant. Sampled only while busy.
- `o_gnt` out N: one-hot grant, registered; all zeros when idle.
- `o_gnt_idx` out IDX_W: index of the granted requester; 0 when idle.
- `o_busy` out 1: high while a grant is outstanding.
- `o_pend` out N: latched pending events, registered.

## Operation
**Synchronizer**
- One chain of `SYNC_STAGES` flops per bit.
- Non-blocking assignments only; each stage is a distinct register.
- No logic between stages.
- The last stage gives `s_req[k]`.
- One extra flop gives `s_req_d[k]`.
- `rise[k] = s_req[k] & ~s_req_d[k]`.

**Pending update**
- `pend_next = (pend & ~issue_mask) | rise`.
- Set wins over clear. A rise in the same cycle a grant is issued to k leaves `pend[k]=1`, i.e. a new event is queued.
- A level held high produces exactly one event.

**FSM (2 states)**
- IDLE:
  - If `|pend`, select the first set bit searching from `(last+1) mod N` upward with wrap.
  - Register `o_gnt`, `o_gnt_idx` and `o_busy=1`, clear that pend bit, and go to GRANT.
  - Otherwise stay in IDLE. `i_done` is ignored.
- GRANT:
  - Hold `o_gnt`/`o_gnt_idx` stable.
  - On `i_done=1`: `last <= o_gnt_idx`, outputs go to 0, go to IDLE.
  - New events keep accumulating in pend.

**Reset**
- Reset values: state IDLE, `last=N-1` (requester 0 has first priority), all sync/pend flops 0, all outputs 0.
- Reset asserted mid-grant drops the grant at the next edge; pending events are discarded.

## Timing
- Latency from `i_req[k]` rise (setup met before edge E1) to `o_gnt[k]=1` is `SYNC_STAGES+2` edges, i.e. after edge E4 by default:
  - E2: `s_req` = 1.
  - E3: pend = 1.
  - E4: grant registered.
- The `o_pend[k]` bit falls on the same edge `o_gnt[k]` rises.
- Grant release: `i_done` high at edge D → `o_gnt=0` after D.
- Next grant after D+1 at the earliest, so there is a minimum 1-cycle gap with `o_busy=0` between grants.
- Minimum request pulse width to be detected: one `i_clk` period plus setup/hold. Shorter pulses may be lost; this is documented behaviour.
- `o_gnt` is never multi-hot and never changes while `o_busy=1`.

## Structure
- Package `req_sync_arbiter_pkg`: typedef enum logic `{ST_IDLE, ST_GRANT}` `arb_state_t`, plus a `rr_pick` function (pending vector, last index → index, valid).
- Sub-module `sync_chain` (parameter `STAGES`; ports `i_clk`, `i_rst`, `i_d`, `o_q`), one instance per requester via generate.
- All remaining logic (pend, FSM, pointer) lives in the top module.

## Test plan
1. **Reset:** hold `i_rst` for 3 cycles while toggling `i_req=4'hF` → `o_gnt=0`, `o_gnt_idx=0`, `o_busy=0`, `o_pend=0` throughout; after release, no stale grant.
2. **Single request:** `i_req[2]` rises before E1 → `o_gnt=4'b0100` and `o_gnt_idx=2` after E4. `i_done` pulse at D → `o_gnt=0`, `o_busy=0` after D.
3. **Simultaneous requests:** `i_req=4'hF` rises together; `i_done` is pulsed 3 cycles after each grant → grants occur in order 0,1,2,3, each separated by a 1-cycle idle gap.
4. **Round-robin fairness:** after grant 1 completes, pend = 4'b0101 → the next grant is 2, then 0.
5. **Level vs edge:** `i_req[1]` held high for 20 cycles → exactly one grant. Drop it for 3 cycles and raise again → exactly one more grant.
6. **Re-request and reset mid-grant:**
   - `i_req[0]` pulses low→high while `o_gnt=4'b0001` → `o_pend[0]=1`, and requester 0 is granted again after done (no others pending).
   - Separately, asserting `i_rst` during GRANT → `o_gnt=0` after the next edge, and pend is cleared.

Source files
------------

// File: rtl/req_sync_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// req_sync_arbiter_pkg
// Shared types and the round-robin selection helper for req_sync_arbiter.
//   arb_state_t : two-state arbiter FSM encoding (idle / grant outstanding)
//   rr_pick_t   : result of a round-robin search (valid flag + index)
//   rr_pick()   : first set bit of a pending vector, searching upward from
//                 (last + 1) mod n with wrap-around
// Vectors are carried at MAX_N width so one function serves any N <= MAX_N.
// ---------------------------------------------------------------------------
package req_sync_arbiter_pkg;

   localparam int MAX_N     = 32;
   localparam int MAX_IDX_W = 5;

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } arb_state_t;

   typedef struct packed {
      logic                 valid;
      logic [MAX_IDX_W-1:0] idx;
   } rr_pick_t;

   // The loop bound is the constant MAX_N so the search unrolls to fixed
   // hardware; candidates beyond the live requester count are masked off.
   function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]     pend,
                                        input logic [MAX_IDX_W-1:0] last,
                                        input int unsigned          n);
      rr_pick_t    res;
      int unsigned cand;
      res = '0;
      for (int unsigned i = 1; i <= MAX_N; i++) begin
         // last < n and i <= n, so a single subtraction performs the wrap.
         cand = 32'(last) + i;
         if (cand >= n) cand = cand - n;
         if (i <= n && !res.valid && pend[cand[MAX_IDX_W-1:0]]) begin
            res.valid = 1'b1;
            res.idx   = cand[MAX_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/req_sync_arbiter_sync.sv
// ---------------------------------------------------------------------------
// sync_chain
// Plain flop-chain synchronizer bringing one asynchronous level into the
// i_clk domain. Every stage is its own register with nothing in between.
//   i_clk : sampling clock (rising edge)
//   i_rst : synchronous active-high reset, clears every stage
//   i_d   : asynchronous input level
//   o_q   : synchronized level (last stage)
// ---------------------------------------------------------------------------
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Pure wiring: stage j+1 takes stage j, stage 0 takes the raw input.
   always_comb sync_d = {sync_q[STAGES-2:0], i_d};

   // NOTE: non-blocking assignment keeps every stage a distinct flop; a
   // blocking assignment here would let the input race straight through.
   always_ff @(posedge i_clk) begin
      if (i_rst) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/req_sync_arbiter.sv
// ---------------------------------------------------------------------------
// req_sync_arbiter
// Round-robin arbiter for N asynchronous requesters sharing one resource.
// Each request is synchronized, rising-edge detected and latched as a pending
// event; events are granted one at a time and held until i_done.
//   i_clk     : clock, all flops on rising edge
//   i_rst     : synchronous active-high reset
//   i_req     : [N] asynchronous request levels, a rising edge is one event
//   i_done    : resource finished the current grant (only looked at in GRANT)
//   o_gnt     : [N] registered one-hot grant, zero when idle
//   o_gnt_idx : [IDX_W] index of the granted requester, zero when idle
//   o_busy    : grant outstanding
//   o_pend    : [N] latched pending events
// IDX_W is derived from N and is not meant to be overridden; N <= 32.
// ---------------------------------------------------------------------------
module req_sync_arbiter
   import req_sync_arbiter_pkg::*;
#(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int IDX_W       = $clog2(N)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [N-1:0]     i_req,
   input  logic             i_done,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_busy,
   output logic [N-1:0]     o_pend
);

   logic [N-1:0] s_req;
   logic [N-1:0] rise;

   arb_state_t       state_q,     state_d;
   logic [IDX_W-1:0] last_q,      last_d;
   logic [N-1:0]     pend_q,      pend_d;
   logic [N-1:0]     gnt_q,       gnt_d;
   logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
   logic             busy_q,      busy_d;
   logic [N-1:0]     s_req_dly_q, s_req_dly_d;

   logic [N-1:0]     issue_mask;
   logic [MAX_N-1:0] pend_ext;
   rr_pick_t         pick;
   logic             pick_unused;

   for (genvar k = 0; k < N; k++) begin : g_sync
      sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_d   (i_req[k]),
         .o_q   (s_req[k])
      );
   end

   // One event per low-to-high transition of the synchronized level.
   assign rise = s_req & ~s_req_dly_q;

   // Index bits above IDX_W are always zero for a valid N.
   assign pick_unused = ^pick;

   // NOTE: every variable written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      busy_d      = busy_q;
      issue_mask  = '0;
      s_req_dly_d = s_req;
      pend_ext    = '0;
      pend_ext[N-1:0] = pend_q;
      pick        = rr_pick(pend_ext, MAX_IDX_W'(last_q), unsigned'(N));

      case (state_q)
         ST_IDLE: begin
            if (pick.valid) begin
               issue_mask[pick.idx[IDX_W-1:0]] = 1'b1;
               gnt_d     = '0;
               gnt_d[pick.idx[IDX_W-1:0]] = 1'b1;
               gnt_idx_d = pick.idx[IDX_W-1:0];
               busy_d    = 1'b1;
               state_d   = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (i_done) begin
               last_d    = gnt_idx_q;
               gnt_d     = '0;
               gnt_idx_d = '0;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end
      endcase

      // Set wins over clear: a fresh rise on the bit being granted re-queues it.
      pend_d = (pend_q & ~issue_mask) | rise;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         last_q      <= IDX_W'(N - 1);   // requester 0 searched first
         pend_q      <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         busy_q      <= 1'b0;
         s_req_dly_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         pend_q      <= pend_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         busy_q      <= busy_d;
         s_req_dly_q <= s_req_dly_d;
      end
   end

   assign o_gnt     = gnt_q;
   assign o_gnt_idx = gnt_idx_q;
   assign o_busy    = busy_q;
   assign o_pend    = pend_q;

endmodule
